// File: rtl/n_palabras_pkg.sv
// Shared types and helpers for the n_palabras byte-to-word assembler.
//   state_e    : assembler states (CHECK only reachable with N_PALABRAS_CHECKSUM_EN)
//   MAX_BYTES  : widest supported word, in bytes
//   xor_bytes  : XOR of the low n bytes of a word (checksum reference)
package n_palabras_pkg;

    localparam int unsigned MAX_BYTES = 8;
    localparam int unsigned MAX_W     = 8 * MAX_BYTES;
    localparam int unsigned LANE_W    = $clog2(MAX_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2
    } state_e;

    // XOR of bytes 0..n-1 of word
    function automatic logic [7:0] xor_bytes(input logic [MAX_W-1:0] word,
                                             input int unsigned       n);
        logic [7:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (i < n) begin
                acc = acc ^ word[i*8 +: 8];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/n_palabras_timer.sv
// Inter-byte idle timer for n_palabras.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : restart count at zero (wins over run/expire)
//   run       : count this cycle
//   expire_c  : combinational; high in the CYCLES-th consecutive run cycle after load
// CYCLES = 0 disables the timer entirely (expire_c tied low).
module n_palabras_timer #(
    parameter int unsigned CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expire_c
);

    generate
        if (CYCLES == 0) begin : g_off
            assign expire_c = 1'b0;
        end else begin : g_on
            localparam int unsigned W = $clog2(CYCLES + 1);

            logic [W-1:0] cnt_q;
            logic [W-1:0] cnt_d;

            // Counter next-state and expiry detect
            always_comb begin
                cnt_d    = cnt_q;
                expire_c = run && !load && (cnt_q == W'(CYCLES - 1));
                if (load) begin
                    cnt_d = '0;
                end else if (expire_c) begin
                    cnt_d = '0;
                end else if (run) begin
                    cnt_d = cnt_q + W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/n_palabras.sv
// Assembles a stream of byte strobes into NUM_BYTES-wide words with a
// held valid/ready output, partial-word timeout and overflow reporting.
//   clk, rst     : clock, asynchronous active-low reset
//   dato/rx_flat : input byte and its one-cycle strobe
//   msb_first    : lane order, sampled on the first byte of each word
//   out_ready    : consumer accepts data_comple while flat_comple is high
//   data_comple  : assembled word, flat_comple its valid (held until accepted)
//   busy         : a partial word is being held
//   err_timeout / err_overflow / err_checksum : one-cycle error pulses
// Optional: N_PALABRAS_CHECKSUM_EN adds a trailing XOR checksum byte per word.
module n_palabras
    import n_palabras_pkg::*;
#(
    parameter int unsigned NUM_BYTES      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             dato,
    input  logic                   rx_flat,
    input  logic                   msb_first,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] data_comple,
    output logic                   flat_comple,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   err_overflow,
    output logic                   err_checksum
);

    localparam int unsigned WORD_W = 8 * NUM_BYTES;
    localparam int unsigned CNT_W  = $clog2(NUM_BYTES + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                msb_q, msb_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                flat_q, flat_d;
    logic                busy_q, busy_d;
    logic                err_to_q, err_to_d;
    logic                err_ov_q, err_ov_d;
`ifdef N_PALABRAS_CHECKSUM_EN
    logic                err_ck_q, err_ck_d;
`endif

    logic                timer_load;
    logic                timer_run;
    logic                timer_expire;
    logic                msb_eff;
    logic [LANE_W-1:0]   lane;
    logic [WORD_W-1:0]   asm_ins;
    logic [WORD_W-1:0]   done_word;
    logic                word_done;
    logic                held;

    n_palabras_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .run      (timer_run),
        .expire_c (timer_expire)
    );

    // Next-state, assembly and output-register logic
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        msb_d      = msb_q;
        asm_d      = asm_q;
        data_d     = data_q;
        flat_d     = flat_q;
        err_to_d   = 1'b0;
        err_ov_d   = 1'b0;
`ifdef N_PALABRAS_CHECKSUM_EN
        err_ck_d   = 1'b0;
`endif
        timer_load = 1'b0;
        timer_run  = (state_q != ST_IDLE);
        word_done  = 1'b0;
        done_word  = asm_q;

        // Lane order comes straight from the input on a word's first byte
        msb_eff = (state_q == ST_IDLE) ? msb_first : msb_q;
        lane    = msb_eff ? (LANE_W'(NUM_BYTES - 1) - LANE_W'(count_q)) : LANE_W'(count_q);

        // Current assembly with the incoming byte dropped into its lane
        asm_ins = (state_q == ST_IDLE) ? '0 : asm_q;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (LANE_W'(i) == lane) begin
                asm_ins[i*8 +: 8] = dato;
            end
        end

        // Output word still waiting for the consumer after this edge
        held = flat_q && !out_ready;

        case (state_q)
            ST_IDLE: begin
                if (rx_flat) begin
                    timer_load = 1'b1;
                    msb_d      = msb_first;
                    asm_d      = asm_ins;
                    count_d    = CNT_W'(1);
                    state_d    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (rx_flat) begin
                    timer_load = 1'b1;
                    asm_d      = asm_ins;
                    if (count_q == CNT_W'(NUM_BYTES - 1)) begin
`ifdef N_PALABRAS_CHECKSUM_EN
                        count_d = CNT_W'(NUM_BYTES);
                        state_d = ST_CHECK;
`else
                        count_d   = '0;
                        state_d   = ST_IDLE;
                        word_done = 1'b1;
                        done_word = asm_ins;
`endif
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else if (timer_expire) begin
                    count_d  = '0;
                    state_d  = ST_IDLE;
                    err_to_d = 1'b1;
                end
            end
`ifdef N_PALABRAS_CHECKSUM_EN
            ST_CHECK: begin
                if (rx_flat) begin
                    timer_load = 1'b1;
                    count_d    = '0;
                    state_d    = ST_IDLE;
                    if (dato == xor_bytes(MAX_W'(asm_q), NUM_BYTES)) begin
                        word_done = 1'b1;
                    end else begin
                        err_ck_d = 1'b1;
                    end
                end else if (timer_expire) begin
                    count_d  = '0;
                    state_d  = ST_IDLE;
                    err_to_d = 1'b1;
                end
            end
`endif
            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // A finished word either replaces a free/accepted output or is dropped
        if (word_done && held) begin
            err_ov_d = 1'b1;
        end else if (word_done) begin
            data_d = done_word;
            flat_d = 1'b1;
        end else begin
            flat_d = held;
        end

        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            msb_q    <= 1'b0;
            asm_q    <= '0;
            data_q   <= '0;
            flat_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_to_q <= 1'b0;
            err_ov_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            msb_q    <= msb_d;
            asm_q    <= asm_d;
            data_q   <= data_d;
            flat_q   <= flat_d;
            busy_q   <= busy_d;
            err_to_q <= err_to_d;
            err_ov_q <= err_ov_d;
        end
    end

`ifdef N_PALABRAS_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_ck_q <= 1'b0;
        end else begin
            err_ck_q <= err_ck_d;
        end
    end
    assign err_checksum = err_ck_q;
`else
    assign err_checksum = 1'b0;
`endif

    assign data_comple  = data_q;
    assign flat_comple  = flat_q;
    assign busy         = busy_q;
    assign err_timeout  = err_to_q;
    assign err_overflow = err_ov_q;

endmodule

// File: tb/tb_n_palabras.sv
// Self-checking bench for n_palabras (NUM_BYTES=4, TIMEOUT_CYCLES=16):
// directed scenarios followed by randomized traffic, all compared against
// a queue-based reference model of the byte-to-word behaviour.
module tb_n_palabras;

    localparam int NB = 4;
    localparam int TO = 16;
`ifdef N_PALABRAS_CHECKSUM_EN
    localparam int WORD_LEN = NB + 1;
`else
    localparam int WORD_LEN = NB;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  dato;
    logic        rx_flat;
    logic        msb_first;
    logic        out_ready;
    logic [31:0] data_comple;
    logic        flat_comple;
    logic        busy;
    logic        err_timeout;
    logic        err_overflow;
    logic        err_checksum;

    n_palabras #(
        .NUM_BYTES      (NB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dato         (dato),
        .rx_flat      (rx_flat),
        .msb_first    (msb_first),
        .out_ready    (out_ready),
        .data_comple  (data_comple),
        .flat_comple  (flat_comple),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow),
        .err_checksum (err_checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model state
    logic [7:0]  m_cur[$];
    bit          m_msb;
    int          m_idle;
    logic [31:0] m_data;
    bit          m_flat;
    bit          m_to;
    bit          m_ov;
    bit          m_ck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur.delete();
        m_msb  = 1'b0;
        m_idle = 0;
        m_data = '0;
        m_flat = 1'b0;
        m_to   = 1'b0;
        m_ov   = 1'b0;
        m_ck   = 1'b0;
    endtask

    // One clock edge of the reference behaviour
    task automatic model_edge(input bit rx, input logic [7:0] d, input bit m, input bit r);
        logic [31:0] w;
        logic [7:0]  x;
        bit          done;
        bit          held;
        w    = '0;
        x    = '0;
        done = 1'b0;
        m_to = 1'b0;
        m_ov = 1'b0;
        m_ck = 1'b0;
        if (rx) begin
            if (m_cur.size() == 0) m_msb = m;
            m_cur.push_back(d);
            m_idle = 0;
            if (m_cur.size() == WORD_LEN) begin
                for (int k = 0; k < NB; k++) begin
                    w = w | (32'(m_cur[k]) << (8 * (m_msb ? (NB - 1 - k) : k)));
                    x = x ^ m_cur[k];
                end
`ifdef N_PALABRAS_CHECKSUM_EN
                if (m_cur[NB] == x) done = 1'b1;
                else m_ck = 1'b1;
`else
                done = 1'b1;
`endif
                m_cur.delete();
            end
        end else if (m_cur.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_cur.delete();
                m_idle = 0;
                m_to   = 1'b1;
            end
        end
        held = m_flat && !r;
        if (done && held) begin
            m_ov = 1'b1;
        end else if (done) begin
            m_data = w;
            m_flat = 1'b1;
        end else begin
            m_flat = held;
        end
    endtask

    task automatic check_outputs();
        check("data_comple",  data_comple,         m_data);
        check("flat_comple",  32'(flat_comple),    32'(m_flat));
        check("busy",         32'(busy),           32'(m_cur.size() != 0));
        check("err_timeout",  32'(err_timeout),    32'(m_to));
        check("err_overflow", 32'(err_overflow),   32'(m_ov));
        check("err_checksum", 32'(err_checksum),   32'(m_ck));
    endtask

    task automatic cycle(input bit rx, input logic [7:0] d, input bit m, input bit r);
        rx_flat   = rx;
        dato      = d;
        msb_first = m;
        out_ready = r;
        @(posedge clk);
        model_edge(rx, d, m, r);
        #1;
        check_outputs();
    endtask

    // Sends bytes w[7:0], w[15:8], ... (plus checksum byte when enabled)
    task automatic send_word(input logic [31:0] w, input bit m0, input bit mr,
                             input bit r, input bit r_last);
        logic [7:0] x;
        x = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        for (int k = 0; k < NB; k++) begin
            cycle(1'b1, w[8*k +: 8], (k == 0) ? m0 : mr,
                  (k == NB - 1 && WORD_LEN == NB) ? r_last : r);
        end
`ifdef N_PALABRAS_CHECKSUM_EN
        cycle(1'b1, x, mr, r_last);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int p_rx;
        int p_rdy;

        rst       = 1'b0;
        rx_flat   = 1'b0;
        dato      = '0;
        msb_first = 1'b0;
        out_ready = 1'b1;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Basic LSB-first word
        send_word(32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
        check("lsb_first_word", data_comple, 32'h44332211);
        check("lsb_first_valid", 32'(flat_comple), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // MSB-first, lane order latched on first byte only
        send_word(32'h44332211, 1'b1, 1'b0, 1'b1, 1'b1);
        check("msb_first_word", data_comple, 32'h11223344);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Timeout discards partial word, then a fresh word assembles cleanly
        cycle(1'b1, 8'h11, 1'b0, 1'b1);
        cycle(1'b1, 8'h22, 1'b0, 1'b1);
        repeat (TO) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("timeout_pulse", 32'(err_timeout), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        send_word(32'hA3A2A1A0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("after_timeout_word", data_comple, 32'hA3A2A1A0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Byte arriving in the would-be timeout cycle is accepted
        cycle(1'b1, 8'h01, 1'b0, 1'b1);
        repeat (TO - 1) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h02, 1'b0, 1'b1);
        check("late_byte_no_timeout", 32'(err_timeout), 32'd0);
        check("late_byte_busy", 32'(busy), 32'd1);
        cycle(1'b1, 8'h03, 1'b0, 1'b1);
        cycle(1'b1, 8'h04, 1'b0, 1'b1);
`ifdef N_PALABRAS_CHECKSUM_EN
        cycle(1'b1, 8'h04, 1'b0, 1'b1);
`endif
        check("late_byte_word", data_comple, 32'h04030201);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure: second word dropped with overflow, held word stable
        send_word(32'h44332211, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(32'h88776655, 1'b0, 1'b0, 1'b0, 1'b0);
        check("overflow_pulse", 32'(err_overflow), 32'd1);
        check("overflow_held", data_comple, 32'h44332211);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("overflow_still_held", data_comple, 32'h44332211);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("after_accept_valid", 32'(flat_comple), 32'd0);

        // Accept and new completion in the same cycle: no overflow
        send_word(32'hDDCCBBAA, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(32'h0F0E0D0C, 1'b0, 1'b0, 1'b0, 1'b1);
        check("same_cycle_word", data_comple, 32'h0F0E0D0C);
        check("same_cycle_no_ovf", 32'(err_overflow), 32'd0);
        check("same_cycle_valid", 32'(flat_comple), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset mid-word
        cycle(1'b1, 8'h11, 1'b0, 1'b1);
        cycle(1'b1, 8'h22, 1'b0, 1'b1);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check("reset_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send_word(32'h88776655, 1'b0, 1'b0, 1'b1, 1'b1);
        check("after_reset_word", data_comple, 32'h88776655);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

`ifdef N_PALABRAS_CHECKSUM_EN
        // Checksum byte mismatch drops the word
        for (int k = 0; k < NB; k++) cycle(1'b1, 8'(8'h11 * (k + 1)), 1'b0, 1'b1);
        cycle(1'b1, 8'h45, 1'b0, 1'b1);
        check("checksum_err", 32'(err_checksum), 32'd1);
        check("checksum_no_valid", 32'(flat_comple), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
`endif

        // Randomized traffic in bursts of differing density
        for (int blk = 0; blk < 12; blk++) begin
            case ($urandom_range(2, 0))
                0:       p_rx = 90;
                1:       p_rx = 40;
                default: p_rx = 4;
            endcase
            case ($urandom_range(2, 0))
                0:       p_rdy = 100;
                1:       p_rdy = 50;
                default: p_rdy = 10;
            endcase
            for (int c = 0; c < 40; c++) begin
                cycle($urandom_range(99, 0) < p_rx, 8'($urandom()),
                      1'($urandom()), $urandom_range(99, 0) < p_rdy);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/n_palabras.md
N_PALABRAS -- requirements
Module: n_palabras

Interface
REQ-001 Parameter NUM_BYTES, default 4, bytes per assembled word, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, idle cycles before a partial word is discarded; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 dato  input  8  received byte, valid when rx_flat=1.
REQ-006 rx_flat  input  1  one-cycle byte strobe.
REQ-007 msb_first  input  1  0: first byte in [7:0]; 1: first byte in MSB lane.
REQ-008 out_ready  input  1  consumer accepts data_comple when high with flat_comple.
REQ-009 data_comple  output  8*NUM_BYTES  assembled word.
REQ-010 flat_comple  output  1  data_comple valid; held until accepted.
REQ-011 busy  output  1  high while a partial word is held (byte count != 0).
REQ-012 err_timeout  output  1  one-cycle pulse on partial-word discard.
REQ-013 err_overflow  output  1  one-cycle pulse on completed word dropped.
REQ-014 err_checksum  output  1  one-cycle pulse on checksum mismatch (macro only).

Function
REQ-015 States: IDLE (count=0), COLLECT (0<count<total), CHECK (macro only, awaiting checksum byte).
REQ-016 Each rx_flat=1 cycle accepts dato, increments count; no other input stalls acceptance.
REQ-017 msb_first is latched on the first byte of a word and applies to the whole word.
REQ-018 Byte k (0-based) goes to lane k (msb_first=0) or lane NUM_BYTES-1-k (msb_first=1).
REQ-019 Word completes on the byte making count=NUM_BYTES; count returns to 0 that edge.
REQ-020 flat_comple and data_comple update on the edge accepting the final byte (1-cycle latency from strobe to visible output).
REQ-021 Transfer occurs when flat_comple=1 and out_ready=1; flat_comple drops next cycle unless a new word completes that same cycle, in which case the new word is presented with flat_comple=1 and no error.
REQ-022 While flat_comple=1 and out_ready=0, data_comple holds stable; assembly of the next word continues in a separate register.
REQ-023 Word completing while output is held and not transferred that cycle is dropped, err_overflow pulses, held word unchanged.
REQ-024 Inter-byte counter resets on every accepted byte and runs only while count!=0.
REQ-025 After TIMEOUT_CYCLES cycles without rx_flat in COLLECT: partial word discarded, count=0, err_timeout pulses.
REQ-026 rx_flat in the cycle the timeout would fire wins: byte accepted, no timeout.
REQ-027 Timeout never affects the output register or flat_comple.

Reset
REQ-028 rst=0 forces count=0, IDLE, timer=0, data_comple=0, flat_comple=0, busy=0, all err_* =0, immediately and regardless of clk.
REQ-029 Reset mid-word discards the partial word; first byte after release starts a new word at k=0.

Configuration
REQ-030 Macro N_PALABRAS_CHECKSUM_EN defined: after NUM_BYTES data bytes, one extra byte is expected in CHECK; equal to XOR of data bytes -> word completes per REQ-019..023; unequal -> word dropped, err_checksum pulses, no flat_comple.
REQ-031 Timeout applies in CHECK as in COLLECT when macro defined.
REQ-032 Macro undefined: no CHECK state, no checksum logic, err_checksum tied 0.

Structure
REQ-033 Package n_palabras_pkg holds state enum typedef, MAX_BYTES=8 constant, and XOR-checksum function.
REQ-034 Timeout counter is sub-module n_palabras_timer (load, run, expire), width $clog2(TIMEOUT_CYCLES+1).

Verification (NUM_BYTES=4, TIMEOUT_CYCLES=16 unless stated)
REQ-035 Bytes 11,22,33,44, msb_first=0, out_ready=1 -> data_comple=0x44332211, flat_comple one cycle after byte 44.
REQ-036 Same bytes, msb_first=1 -> 0x11223344; toggling msb_first after byte 11 has no effect.
REQ-037 Bytes 11,22 then 16 idle cycles -> err_timeout pulse, busy=0; then A0,A1,A2,A3 -> 0xA3A2A1A0.
REQ-038 out_ready=0; words 0x44332211 then 0x88776655 -> err_overflow on second completion, data_comple stays 0x44332211 until out_ready=1.
REQ-039 rst=0 after bytes 11,22; release; bytes 55,66,77,88 -> 0x88776655, no error pulses.
REQ-040 Macro defined: 11,22,33,44,44 -> 0x44332211 valid; 11,22,33,44,45 -> err_checksum, flat_comple stays 0.
